// File: rtl/i2c_slave_if.sv
// i2c_slave_if: single-address I2C target. Oversamples scl/sda on clk,
// decodes START/STOP, ACKs a matching address, delivers write bytes to
// local logic and serializes local read data. sda is open-drain only.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | bus ignored until a START is seen
// ADDR      | shifting in the address byte (7-bit address + R/W)
// ADDR_ACK  | address matched; pulling sda low for the ACK bit
// RX        | shifting in a write data byte
// RX_ACK    | pulling sda low to ACK a received write byte
// TX        | serializing a read byte onto sda, MSB first
// TX_ACK    | sda released; sampling the master ACK/NACK
// WAIT_STOP | not addressed or master NACKed; wait for STOP/START
module i2c_slave_if #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h4E,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   inout  wire        sda,
   input  logic [7:0] txdata,
   output logic [7:0] rxdata,
   output logic       rxvalid,
   output logic       txreq,
   output logic       addr_match,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      ADDR_ACK  = 3'd2,
      RX        = 3'd3,
      RX_ACK    = 3'd4,
      TX        = 3'd5,
      TX_ACK    = 3'd6,
      WAIT_STOP = 3'd7
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_s;
   logic                   sda_s;
   logic                   scl_q;
   logic                   sda_q;
   logic                   scl_rise;
   logic                   scl_fall;
   logic                   start_det;
   logic                   stop_det;

   state_t     state_q,   state_d;
   logic [3:0] bitcnt_q,  bitcnt_d;
   logic [7:0] shreg_q,   shreg_d;
   logic       rw_q,      rw_d;
   logic       sda_oe_q,  sda_oe_d;
   logic [7:0] rxdata_d;
   logic       rxvalid_d;
   logic       txreq_d;
   logic       addr_match_d;
   logic       busy_d;
   logic [7:0] rx_byte;

   // Open-drain: only ever pull low or release.
   assign sda = sda_oe_q ? 1'b0 : 1'bz;

   // Synchronizers reset to the idle-bus level so reset release never
   // fabricates a START.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
         scl_q    <= scl_s;
         sda_q    <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_q;
   assign scl_fall  = ~scl_s & scl_q;
   // Only the current scl level is required, so a START landing on the
   // same clk as an scl edge still wins over bit handling.
   assign start_det = scl_s & sda_q & ~sda_s;
   assign stop_det  = scl_s & ~sda_q & sda_s;
   assign rx_byte   = {shreg_q[6:0], sda_s};

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         bitcnt_q   <= 4'd0;
         shreg_q    <= 8'h00;
         rw_q       <= 1'b0;
         sda_oe_q   <= 1'b0;
         rxdata     <= 8'h00;
         rxvalid    <= 1'b0;
         txreq      <= 1'b0;
         addr_match <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         shreg_q    <= shreg_d;
         rw_q       <= rw_d;
         sda_oe_q   <= sda_oe_d;
         rxdata     <= rxdata_d;
         rxvalid    <= rxvalid_d;
         txreq      <= txreq_d;
         addr_match <= addr_match_d;
         busy       <= busy_d;
      end
   end

   // Next-state and output decode; bus conditions override bit handling.
   always_comb begin
      state_d      = state_q;
      bitcnt_d     = bitcnt_q;
      shreg_d      = shreg_q;
      rw_d         = rw_q;
      sda_oe_d     = sda_oe_q;
      rxdata_d     = rxdata;
      rxvalid_d    = 1'b0;
      txreq_d      = 1'b0;
      addr_match_d = addr_match;
      busy_d       = busy;

      if (stop_det) begin
         state_d      = IDLE;
         bitcnt_d     = 4'd0;
         sda_oe_d     = 1'b0;
         busy_d       = 1'b0;
         addr_match_d = 1'b0;
      end else if (start_det) begin
         state_d      = ADDR;
         bitcnt_d     = 4'd0;
         sda_oe_d     = 1'b0;
         busy_d       = 1'b1;
         addr_match_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
            end
            ADDR: begin
               if (scl_rise) begin
                  shreg_d  = rx_byte;
                  bitcnt_d = bitcnt_q + 4'd1;
                  if (bitcnt_q == 4'd7) begin
                     bitcnt_d = 4'd0;
                     rw_d     = sda_s;
                     if (rx_byte[7:1] == SLAVE_ADDR) begin
                        state_d      = ADDR_ACK;
                        addr_match_d = 1'b1;
                     end else begin
                        state_d = WAIT_STOP;
                     end
                  end
               end
            end
            // First falling edge starts the ACK, the second one ends it.
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else if (rw_q) begin
                     txreq_d  = 1'b1;
                     shreg_d  = {txdata[6:0], 1'b0};
                     sda_oe_d = ~txdata[7];
                     bitcnt_d = 4'd1;
                     state_d  = TX;
                  end else begin
                     sda_oe_d = 1'b0;
                     bitcnt_d = 4'd0;
                     state_d  = RX;
                  end
               end
            end
            RX: begin
               if (scl_rise) begin
                  shreg_d  = rx_byte;
                  bitcnt_d = bitcnt_q + 4'd1;
                  if (bitcnt_q == 4'd7) begin
                     rxdata_d  = rx_byte;
                     rxvalid_d = 1'b1;
                     bitcnt_d  = 4'd0;
                     state_d   = RX_ACK;
                  end
               end
            end
            RX_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = RX;
                  end
               end
            end
            // bitcnt counts bits already placed on sda.
            TX: begin
               if (scl_fall) begin
                  if (bitcnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     bitcnt_d = 4'd0;
                     state_d  = TX_ACK;
                  end else begin
                     sda_oe_d = ~shreg_q[7];
                     shreg_d  = {shreg_q[6:0], 1'b0};
                     bitcnt_d = bitcnt_q + 4'd1;
                  end
               end
            end
            // bitcnt=1 marks a received ACK awaiting the falling edge.
            TX_ACK: begin
               if (scl_rise) begin
                  if (sda_s) begin
                     state_d = WAIT_STOP;
                  end else begin
                     bitcnt_d = 4'd1;
                  end
               end else if (scl_fall && bitcnt_q == 4'd1) begin
                  txreq_d  = 1'b1;
                  shreg_d  = {txdata[6:0], 1'b0};
                  sda_oe_d = ~txdata[7];
                  bitcnt_d = 4'd1;
                  state_d  = TX;
               end
            end
            WAIT_STOP: begin
               sda_oe_d = 1'b0;
            end
            default: begin
               state_d  = IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave_if.sv
// Directed bench for i2c_slave_if: a bit-banged I2C master drives scl/sda,
// a table of write/mismatch frames is applied in a loop, and read, abort
// and reset corner cases follow as hand-written sequences.
module tb_i2c_slave_if;
   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       scl = 1'b1;
   logic       sda_low = 1'b0;
   logic [7:0] txdata = 8'h00;
   wire        sda;
   logic [7:0] rxdata;
   logic       rxvalid;
   logic       txreq;
   logic       addr_match;
   logic       busy;

   assign sda = sda_low ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_slave_if #(.SLAVE_ADDR(7'h4E), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .scl(scl), .sda(sda), .txdata(txdata),
      .rxdata(rxdata), .rxvalid(rxvalid), .txreq(txreq),
      .addr_match(addr_match), .busy(busy)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;
   int rxv_cnt = 0;
   int txr_cnt = 0;
   int drv_cnt = 0;

   // Pulse counters and a count of clks where the DUT pulls sda low.
   always @(posedge clk) begin
      if (rxvalid) rxv_cnt++;
      if (txreq) txr_cnt++;
      if (sda === 1'b0 && !sda_low) drv_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_bit(input logic b, output logic obs);
      sda_low = ~b;
      clks(HALF);
      scl = 1'b1;
      clks(HALF / 2);
      obs = sda;
      clks(HALF / 2);
      scl = 1'b0;
      clks(2);
   endtask

   task automatic i2c_start();
      sda_low = 1'b1;
      clks(HALF);
      scl = 1'b0;
      clks(2);
   endtask

   task automatic i2c_rstart();
      sda_low = 1'b0;
      clks(HALF);
      scl = 1'b1;
      clks(HALF);
      sda_low = 1'b1;
      clks(HALF);
      scl = 1'b0;
      clks(2);
   endtask

   task automatic i2c_stop();
      sda_low = 1'b1;
      clks(HALF);
      scl = 1'b1;
      clks(HALF);
      sda_low = 1'b0;
      clks(HALF);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic dummy;
      for (int i = 7; i >= 0; i--) do_bit(b[i], dummy);
      do_bit(1'b1, ack);
   endtask

   // nack=1 releases the ACK slot; slot returns what was seen there.
   task automatic read_byte(input logic nack, input logic [7:0] next_tx,
                            output logic [7:0] byt, output logic slot);
      logic o;
      for (int i = 7; i >= 0; i--) begin
         do_bit(1'b1, o);
         byt[i] = o;
         if (i == 7) txdata = next_tx;
      end
      do_bit(nack, slot);
   endtask

   typedef struct {
      logic [7:0] b0;
      logic [7:0] b1;
      logic       exp_ack0;
      logic       exp_ack1;
      logic [7:0] exp_rx;
      int         exp_rxv;
      logic       exp_match;
   } wvec_t;

   wvec_t tbl[6];

   initial begin
      logic       a0, a1, a2, slot, o;
      logic [7:0] byt;
      int         rxv0, txr0, drv0;
      logic [7:0] abort_bits;

      tbl[0] = '{8'h9C, 8'hAD, 1'b0, 1'b0, 8'hAD, 1, 1'b1};
      tbl[1] = '{8'h9C, 8'h00, 1'b0, 1'b0, 8'h00, 1, 1'b1};
      tbl[2] = '{8'h9C, 8'hFF, 1'b0, 1'b0, 8'hFF, 1, 1'b1};
      tbl[3] = '{8'h8D, 8'h55, 1'b1, 1'b1, 8'hFF, 0, 1'b0};
      tbl[4] = '{8'h9E, 8'h12, 1'b1, 1'b1, 8'hFF, 0, 1'b0};
      tbl[5] = '{8'h9C, 8'h3C, 1'b0, 1'b0, 8'h3C, 1, 1'b1};

      clks(3);
      chk("reset sda released", {31'd0, sda}, 32'd1);
      chk("reset rxdata", {24'd0, rxdata}, 32'h00);
      chk("reset flags", {28'd0, rxvalid, txreq, addr_match, busy}, 32'd0);
      rst = 1'b1;
      clks(5);

      for (int t = 0; t < 6; t++) begin
         rxv0 = rxv_cnt;
         txr0 = txr_cnt;
         drv0 = drv_cnt;
         i2c_start();
         write_byte(tbl[t].b0, a0);
         write_byte(tbl[t].b1, a1);
         chk($sformatf("v%0d addr ack", t), {31'd0, a0}, {31'd0, tbl[t].exp_ack0});
         chk($sformatf("v%0d data ack", t), {31'd0, a1}, {31'd0, tbl[t].exp_ack1});
         chk($sformatf("v%0d busy mid", t), {31'd0, busy}, 32'd1);
         chk($sformatf("v%0d addr_match mid", t), {31'd0, addr_match}, {31'd0, tbl[t].exp_match});
         i2c_stop();
         clks(4);
         chk($sformatf("v%0d busy after stop", t), {31'd0, busy}, 32'd0);
         chk($sformatf("v%0d addr_match after stop", t), {31'd0, addr_match}, 32'd0);
         chk($sformatf("v%0d rxdata", t), {24'd0, rxdata}, {24'd0, tbl[t].exp_rx});
         chk($sformatf("v%0d rxvalid pulses", t), rxv_cnt - rxv0, tbl[t].exp_rxv);
         chk($sformatf("v%0d txreq pulses", t), txr_cnt - txr0, 0);
         if (!tbl[t].exp_match)
            chk($sformatf("v%0d sda never driven", t), drv_cnt - drv0, 0);
      end

      // Single read of 0xE6, master NACKs.
      txdata = 8'hE6;
      txr0 = txr_cnt;
      i2c_start();
      write_byte(8'h9D, a0);
      chk("read addr ack", {31'd0, a0}, 32'd0);
      read_byte(1'b1, 8'hE6, byt, slot);
      chk("read byte", {24'd0, byt}, 32'hE6);
      chk("read ack slot released", {31'd0, slot}, 32'd1);
      chk("read txreq pulses", txr_cnt - txr0, 1);
      i2c_stop();
      clks(4);
      chk("read busy after stop", {31'd0, busy}, 32'd0);

      // Two-byte read: ACK then NACK; txdata changes after the first latch.
      txdata = 8'h11;
      txr0 = txr_cnt;
      i2c_start();
      write_byte(8'h9D, a0);
      read_byte(1'b0, 8'h22, byt, slot);
      chk("multi byte0", {24'd0, byt}, 32'h11);
      read_byte(1'b1, 8'h22, byt, slot);
      chk("multi byte1", {24'd0, byt}, 32'h22);
      chk("multi ack slot released", {31'd0, slot}, 32'd1);
      chk("multi txreq pulses", txr_cnt - txr0, 2);
      i2c_stop();
      clks(4);

      // Repeated START after 4 data bits, then a full write of 0x5A.
      rxv0 = rxv_cnt;
      abort_bits = 8'hA0;
      i2c_start();
      write_byte(8'h9C, a0);
      for (int i = 7; i >= 4; i--) do_bit(abort_bits[i], o);
      i2c_rstart();
      chk("abort addr_match cleared", {31'd0, addr_match}, 32'd0);
      chk("abort busy held", {31'd0, busy}, 32'd1);
      chk("abort no partial rxvalid", rxv_cnt - rxv0, 0);
      write_byte(8'h9C, a1);
      write_byte(8'h5A, a2);
      i2c_stop();
      clks(4);
      chk("abort acks", {30'd0, a1, a2}, 32'd0);
      chk("abort rxdata", {24'd0, rxdata}, 32'h5A);
      chk("abort rxvalid pulses", rxv_cnt - rxv0, 1);

      // STOP in the middle of a read byte; DUT must go idle and stay quiet.
      txdata = 8'hE6;
      i2c_start();
      write_byte(8'h9D, a0);
      do_bit(1'b1, o);
      do_bit(1'b1, o);
      i2c_stop();
      clks(1);
      chk("stop mid-tx sda released", {31'd0, sda}, 32'd1);
      chk("stop mid-tx busy", {31'd0, busy}, 32'd0);
      drv0 = drv_cnt;
      for (int i = 0; i < 9; i++) begin
         scl = 1'b0;
         do_bit(1'b1, o);
         scl = 1'b1;
      end
      chk("stop mid-tx no drive after", drv_cnt - drv0, 0);
      clks(HALF);

      // Reset while the DUT drives a '0' read bit.
      txdata = 8'h0F;
      i2c_start();
      write_byte(8'h9D, a0);
      clks(4);
      chk("pre-reset sda driven low", {31'd0, sda}, 32'd0);
      rst = 1'b0;
      #1;
      chk("reset sda released", {31'd0, sda}, 32'd1);
      chk("reset flags mid", {28'd0, rxvalid, txreq, addr_match, busy}, 32'd0);
      chk("reset rxdata mid", {24'd0, rxdata}, 32'h00);
      clks(3);
      rst = 1'b1;
      clks(3);
      drv0 = drv_cnt;
      write_byte(8'h9C, a0);
      chk("post-reset no ack", {31'd0, a0}, 32'd1);
      chk("post-reset no drive", drv_cnt - drv0, 0);
      chk("post-reset busy", {31'd0, busy}, 32'd0);
      scl = 1'b1;
      sda_low = 1'b0;
      clks(HALF);
      i2c_start();
      write_byte(8'h9C, a0);
      write_byte(8'h33, a1);
      i2c_stop();
      clks(4);
      chk("post-reset write acks", {30'd0, a0, a1}, 32'd0);
      chk("post-reset rxdata", {24'd0, rxdata}, 32'h33);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/i2c_slave_if.md
Name: i2c_slave_if

Overview:
Single-address I2C target that sits directly downstream of i2cmaster on the shared scl/sda bus. It decodes START/STOP, matches a 7-bit address, ACKs and delivers received write bytes to local logic, and serializes local read data back to the master. It oversamples scl/sda on the system clock and drives sda open-drain only.

Parameters:
SLAVE_ADDR, 7'h4E, 7-bit device address compared against bits [7:1] of the first byte after START.
SYNC_STAGES, 2, number of synchronizer flops on scl and sda (minimum 2).

Ports:
clk  input  1  system clock; all logic is in this domain.
rst  input  1  asynchronous, active-low reset (0 = reset).
scl  input  1  I2C clock from the master.
sda  inout  1  I2C data, open-drain: driven 1'b0 or released to 1'bz, never driven 1.
txdata  input  8  byte to return on a read; sampled when txreq pulses.
rxdata  output  8  last byte written by the master.
rxvalid  output  1  one-clk pulse when rxdata updates.
txreq  output  1  one-clk pulse when txdata is latched into the shift register.
addr_match  output  1  high from address ACK until STOP or repeated START.
busy  output  1  high between START and STOP, whether or not the address matched.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; rxdata=8'h00; rxvalid, txreq, addr_match, busy = 0; sda released; bit counter = 0.
- Synchronizers: scl_s and sda_s pass through SYNC_STAGES flops; edges are detected on the synchronized signals. The master must hold scl high and low for at least SYNC_STAGES+2 clk each.
- START: sda_s falls while scl_s is high. STOP: sda_s rises while scl_s is high. Both are recognised in every state and take priority over bit sampling.
- Sampling and drive timing: sda is sampled on scl_s rising edges. Slave-driven sda changes only on the clk after an scl_s falling edge.
- States:
  - IDLE: on START -> ADDR, busy=1, bit counter=0.
  - ADDR: shift 8 bits MSB first. After bit 8, if [7:1]==SLAVE_ADDR -> ADDR_ACK; otherwise -> WAIT_STOP and sda is never driven.
  - ADDR_ACK: drive sda low from the 8th falling edge to the 9th falling edge; addr_match=1. If R/W (bit0)=0 -> RX. If R/W=1 -> TX; txdata is latched and txreq pulses on that 9th falling edge, and the MSB is driven in the same step.
  - RX: shift 8 bits. On the 8th rising edge, rxdata <= shifted byte and rxvalid pulses one clk (at most SYNC_STAGES+2 clk after the scl edge). -> RX_ACK.
  - RX_ACK: drive sda low for the ACK bit, then -> RX for the next byte.
  - TX: on each falling edge, drive the next bit; a '1' bit releases sda. After the 8th bit's falling edge, release sda -> TX_ACK.
  - TX_ACK: sample master ACK on the rising edge. 0 -> reload txdata (txreq pulse) and return to TX on the falling edge. 1 (NACK) -> WAIT_STOP.
  - WAIT_STOP: sda released; wait for STOP or START.
- STOP in any state: -> IDLE; sda released the same clk; busy, addr_match = 0. A partial byte is discarded and rxvalid does not pulse.
- Repeated START in any state: -> ADDR, bit counter cleared, addr_match=0, sda released, busy stays 1.
- Reset mid-transfer releases sda immediately. After reset is released, the block ignores the bus until the next START.
- Simultaneous START and scl edge in the same clk: START wins.
- rxdata holds its value until the next completed write byte.

Test Plan:
- Write: START, 0x9C (0x4E+W), 0xAD, STOP. Required: sda pulled low on both ACK bits; rxdata=0xAD; exactly one rxvalid pulse; busy falls after STOP.
- Read: START, 0x9D, txdata=0xE6, master NACKs. Required: one txreq; sda serializes 1,1,1,0,0,1,1,0; sda released in the ACK slot; state returns to IDLE after STOP.
- Address mismatch: START, 0x8D. Required: no ACK; sda stays Z for the whole frame; addr_match=0; busy=1 until STOP; no rxvalid or txreq.
- Multi-byte read: txdata 0x11 then 0x22 with master ACK then NACK. Required: two txreq pulses; bytes 0x11 and 0x22 appear on sda.
- Abort: repeated START after 4 data bits of a write, then a new write of 0x5A. Required: no rxvalid for the partial byte; rxdata=0x5A. Also, STOP mid-TX releases sda within 1 clk.
- Reset: rst=0 while driving a TX '0' bit. Required: sda Z in the same cycle; all outputs 0; the next STOP-free traffic is ignored until a new START.
